// File: rtl/fetch_pkg.sv
// Shared widths, halt opcode, FSM state type and FIFO entry layout for the fetch path.
package fetch_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] HLT_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// ROM, redirect and decode-side signals of the fetch controller.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, flush beats push, push into a full FIFO is legal only with a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign rdata  = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers, count and storage; flush empties the FIFO and ignores push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer/count registers with synchronous reset; the issue rule must never let a push overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (!flush) begin
        assert (!(push && full && !do_pop)) else $error("fetch_fifo overflow");
      end
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: drives the 1-cycle-latency ROM, tags words with their PC, queues them for decode.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | issuing reads whenever FIFO + in-flight slot has room
// HALTED | HLT word was queued; no issue, late responses dropped
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  fetch_controller_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;

  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic [ADDR_W-1:0] addr;
  entry_t            push_entry;
  entry_t            head;

  assign push_entry = '{instr: bus.mem_data, pc: fetch_pc_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs are forced quiet while reset is held so the ROM and decode see a clean start.
  assign bus.out_valid = rst_n && !fifo_empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.halted    = rst_n && (state_q == HALTED) && fifo_empty;
  assign bus.mem_addr  = rst_n ? addr : '0;
  assign pop           = bus.out_valid && bus.out_ready;
  assign occupancy     = OCC_W'(fifo_count) - OCC_W'(pop) + OCC_W'(inflight_q);

  // Next state, PC and issue decisions; a redirect overrides responses and the issue rule.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    addr       = pc_q;
    if (bus.redirect_valid) begin
      flush      = 1'b1;
      addr       = bus.redirect_target;
      pc_d       = bus.redirect_target + ADDR_W'(1);
      fetch_pc_d = bus.redirect_target;
      inflight_d = 1'b1;
      state_d    = FETCH;
    end else if (state_q == FETCH) begin
      if (inflight_q) begin
        push = 1'b1;
        if (bus.mem_data == HLT_WORD) begin
          state_d = HALTED;
        end
      end
      if (occupancy < OCC_W'(DEPTH)) begin
        pc_d       = pc_q + ADDR_W'(1);
        fetch_pc_d = pc_q;
        inflight_d = 1'b1;
      end
    end
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a 1-cycle synchronous ROM model.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  logic [DATA_W-1:0] rom [1024];
  int n_cmp;
  int n_bad;

  fetch_controller_if bus ();

  fetch_controller #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!bus.halted && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus.halted !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: halted=%b after %0d cycles, expected 1", name, bus.halted, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0] = 32'h0002_08C0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.halted !== 1'b0) begin
      n_bad++; $display("FAIL reset_halted: got %b expected 0", bus.halted);
    end
    n_cmp++;
    if (bus.mem_addr !== 10'd0) begin
      n_bad++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr);
    end
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL boot_early_valid: got %b expected 0", bus.out_valid);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0 || bus.out_instr !== 32'h0002_08C0) begin
      n_bad++;
      $display("FAIL boot_pc0: got v=%b pc=%0d instr=%h expected v=1 pc=0 instr=000208c0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd1 || bus.out_instr !== 32'h0) begin
      n_bad++;
      $display("FAIL boot_hlt: got v=%b pc=%0d instr=%h expected v=1 pc=1 instr=0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    n_cmp++;
    if (bus.halted !== 1'b1) begin
      n_bad++; $display("FAIL boot_halted: got %b expected 1", bus.halted);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1) begin
        n_bad++;
        $display("FAIL boot_quiet[%0d]: got v=%b h=%b expected v=0 h=1", i, bus.out_valid, bus.halted);
      end
    end
  endtask

  task automatic test_redirect_halted();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'd0;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0) begin
      n_bad++;
      $display("FAIL unhalt_edge: got v=%b h=%b expected v=0 h=0", bus.out_valid, bus.halted);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0 || bus.out_instr !== 32'h0002_08C0) begin
      n_bad++;
      $display("FAIL unhalt_pc0: got v=%b pc=%0d instr=%h expected v=1 pc=0 instr=000208c0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    wait_halt("unhalt_rehalt");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) rom[i] = 32'h1000_0001 + i;
    rom[8] = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0 || bus.out_instr !== 32'h1000_0001) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%0d instr=%h expected v=1 pc=0 instr=10000001",
                 i, bus.out_valid, bus.out_pc, bus.out_instr);
      end
      n_cmp++;
      if (bus.mem_addr !== 10'd2) begin
        n_bad++; $display("FAIL stall_addr[%0d]: got %0d expected 2", i, bus.mem_addr);
      end
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'(k) || bus.out_instr !== 32'h1000_0001 + k) begin
        n_bad++;
        $display("FAIL stream_pc%0d: got v=%b pc=%0d instr=%h expected v=1 pc=%0d instr=%h",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, k, 32'h1000_0001 + k);
      end
      step();
    end
    wait_halt("stall_halt");
  endtask

  task automatic test_redirect();
    for (int i = 12; i < 16; i++) rom[i] = 32'h2000_0000 + i;
    rom[16] = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd3) begin
      n_bad++; $display("FAIL redir_head: got v=%b pc=%0d expected v=1 pc=3", bus.out_valid, bus.out_pc);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'd12;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_flush: got v=%b pc=%0d expected v=0", bus.out_valid, bus.out_pc);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd12 || bus.out_instr !== 32'h2000_000C) begin
      n_bad++;
      $display("FAIL redir_pc12: got v=%b pc=%0d instr=%h expected v=1 pc=12 instr=2000000c",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd13) begin
      n_bad++; $display("FAIL redir_pc13: got v=%b pc=%0d expected v=1 pc=13", bus.out_valid, bus.out_pc);
    end
    wait_halt("redir_halt");
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_pc [4];
    exp_pc[0] = 10'd1022; exp_pc[1] = 10'd1023; exp_pc[2] = 10'd0; exp_pc[3] = 10'd1;
    rom[1022] = 32'h3000_03FE;
    rom[1023] = 32'h3000_03FF;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'd1022;
    step();
    bus.redirect_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[k] || bus.out_instr !== rom[exp_pc[k]]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got v=%b pc=%0d instr=%h expected v=1 pc=%0d instr=%h",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[k], rom[exp_pc[k]]);
      end
      step();
    end
    wait_halt("wrap_halt");
  endtask

  task automatic test_midrun_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'd0;
    step();
    bus.redirect_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd2) begin
      n_bad++; $display("FAIL mid_pre: got v=%b pc=%0d expected v=1 pc=2", bus.out_valid, bus.out_pc);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.mem_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b addr=%0d expected v=0 addr=0", bus.out_valid, bus.mem_addr);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_stale: got v=%b pc=%0d expected v=0", bus.out_valid, bus.out_pc);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0 || bus.out_instr !== 32'h1000_0001) begin
      n_bad++;
      $display("FAIL mid_restart: got v=%b pc=%0d instr=%h expected v=1 pc=0 instr=10000001",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd1) begin
      n_bad++; $display("FAIL mid_next: got v=%b pc=%0d expected v=1 pc=1", bus.out_valid, bus.out_pc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_boot();
    test_redirect_halted();
    test_stall();
    test_redirect();
    test_wrap();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
